// File: rtl/delay_alloc_unit.sv
// rtl/delay_alloc_unit.sv - per-pipeline delay-line region allocator with zero-fill and slot commit
module delay_alloc_unit #(
   parameter int mem_addr_width = 16,
   parameter int n_slots        = 16,
   parameter int req_width      = 32
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [1:0]                   alloc_delay,
   input  logic [req_width-1:0]         delay_size_in,
   input  logic [req_width-1:0]         init_delay_in,
   input  logic [1:0]                   pipeline_full_reset,
   output logic                         mem_clear_we,
   output logic [mem_addr_width-1:0]    mem_clear_addr,
   output logic [1:0]                   slot_write,
   output logic [$clog2(n_slots)-1:0]   slot_index,
   output logic [mem_addr_width-1:0]    slot_base,
   output logic [mem_addr_width-1:0]    slot_size,
   output logic [mem_addr_width-1:0]    slot_init,
   output logic                         alloc_busy,
   output logic [1:0]                   alloc_fail,
   output logic                         alloc_overrun
);

   localparam int idx_w = $clog2(n_slots);
   localparam int cnt_w = idx_w + 1;
   localparam int cmp_w = (req_width > mem_addr_width) ? req_width : mem_addr_width;
   localparam logic [mem_addr_width-1:0] half = {1'b1, {(mem_addr_width-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CHECK, CLEAR, COMMIT} state_t;

   state_t state_q, state_d;

   logic                      pend_valid;
   logic                      pend_p;
   logic [req_width-1:0]      pend_size;
   logic [req_width-1:0]      pend_init;

   logic                      cur_p;
   logic [req_width-1:0]      cur_size;
   logic [req_width-1:0]      cur_init;

   logic [mem_addr_width-1:0] ptr   [2];
   logic [cnt_w-1:0]          count [2];

   logic [mem_addr_width-1:0] clear_addr;
   logic [mem_addr_width-1:0] clear_left;

   logic [mem_addr_width-1:0] cur_ptr;
   logic [cnt_w-1:0]          cur_count;
   logic [mem_addr_width-1:0] avail;
   logic [mem_addr_width-1:0] base;
   logic                      abort;
   logic                      check_fail;
   logic                      pop;
   logic                      discard;
   logic                      pend_free;
   logic [1:0]                eff_req;
   logic                      commit_ok;
   logic                      last_clear;

   assign cur_ptr    = ptr[cur_p];
   assign cur_count  = count[cur_p];
   assign avail      = half - cur_ptr;
   assign base       = (cur_p ? half : '0) + cur_ptr;
   assign abort      = pipeline_full_reset[cur_p];

   // Range checks use the full request width so oversized upper bits cannot alias into range.
   assign check_fail = (cur_size == '0) ||
                       (cmp_w'(cur_size) > cmp_w'(avail)) ||
                       (cur_init >= cur_size) ||
                       (cur_count == cnt_w'(n_slots));

   assign pop        = (state_q == IDLE) && pend_valid && !pipeline_full_reset[pend_p];
   assign discard    = pend_valid && pipeline_full_reset[pend_p];
   assign pend_free  = !pend_valid || pop || discard;
   assign eff_req    = alloc_delay & ~pipeline_full_reset;
   assign commit_ok  = (state_q == COMMIT) && !abort;
   assign last_clear = (state_q == CLEAR) && (clear_left == mem_addr_width'(1)) && !abort;

   assign mem_clear_we   = (state_q == CLEAR);
   assign mem_clear_addr = clear_addr;
   assign slot_write     = commit_ok ? (cur_p ? 2'b10 : 2'b01) : 2'b00;
   assign alloc_busy     = (state_q != IDLE) || pend_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pop) state_d = CHECK;
         CHECK:   state_d = (abort || check_fail) ? IDLE : CLEAR;
         CLEAR: begin
            if (abort)                                 state_d = IDLE;
            else if (clear_left == mem_addr_width'(1)) state_d = COMMIT;
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Single-entry request holding register; a pop and a new capture may share a cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_valid    <= 1'b0;
         pend_p        <= 1'b0;
         pend_size     <= '0;
         pend_init     <= '0;
         alloc_overrun <= 1'b0;
      end else begin
         if (eff_req != 2'b00) begin
            if (pend_free) begin
               pend_valid <= 1'b1;
               pend_p     <= ~eff_req[0];
               pend_size  <= delay_size_in;
               pend_init  <= init_delay_in;
            end else begin
               alloc_overrun <= 1'b1;
            end
            if (eff_req == 2'b11) alloc_overrun <= 1'b1;
         end else if (pop || discard) begin
            pend_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_p      <= 1'b0;
         cur_size   <= '0;
         cur_init   <= '0;
         clear_addr <= '0;
         clear_left <= '0;
      end else begin
         if (pop) begin
            cur_p    <= pend_p;
            cur_size <= pend_size;
            cur_init <= pend_init;
         end
         if (state_q == CHECK) begin
            clear_addr <= base;
            clear_left <= cur_size[mem_addr_width-1:0];
         end else if (state_q == CLEAR) begin
            clear_addr <= clear_addr + mem_addr_width'(1);
            clear_left <= clear_left - mem_addr_width'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_index <= '0;
         slot_base  <= '0;
         slot_size  <= '0;
         slot_init  <= '0;
      end else if (last_clear) begin
         slot_index <= cur_count[idx_w-1:0];
         slot_base  <= base;
         slot_size  <= cur_size[mem_addr_width-1:0];
         slot_init  <= cur_init[mem_addr_width-1:0];
      end
   end

   // A full reset takes priority over a commit or failure on the same pipeline.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < 2; p++) begin
            ptr[p]        <= '0;
            count[p]      <= '0;
            alloc_fail[p] <= 1'b0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (pipeline_full_reset[p]) begin
               ptr[p]        <= '0;
               count[p]      <= '0;
               alloc_fail[p] <= 1'b0;
            end else begin
               if (commit_ok && (cur_p == 1'(p))) begin
                  ptr[p]   <= ptr[p] + cur_size[mem_addr_width-1:0];
                  count[p] <= count[p] + cnt_w'(1);
               end
               if ((state_q == CHECK) && (cur_p == 1'(p)) && check_fail)
                  alloc_fail[p] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/delay_alloc_unit.md
Name: delay_alloc_unit

Overview:
- Services the control unit's per-pipeline delay-allocation pulses (alloc_delay, delay_size_out, init_delay_out).
- Carves contiguous regions out of the shared delay-line memory and zero-fills each region before use.
- Publishes each committed region (base/size/initial tap) into the target pipeline's delay slot table.
- Memory is split in two equal halves: pipeline 0 owns the lower half, pipeline 1 the upper; each half has its own bump pointer, freed wholesale on pipeline full reset.

Parameters:
- mem_addr_width, 16, delay memory address width (2^mem_addr_width words total; half per pipeline).
- n_slots, 16, delay slots per pipeline.
- req_width, 32, width of size/init request fields.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- alloc_delay  in  2  one-cycle request pulse, bit p = pipeline p
- delay_size_in  in  req_width  requested region length in words (valid with alloc_delay)
- init_delay_in  in  req_width  initial read-tap offset (valid with alloc_delay)
- pipeline_full_reset  in  2  frees all regions/slots of pipeline p
- mem_clear_we  out  1  zero-write strobe to delay memory
- mem_clear_addr  out  mem_addr_width  zero-write address
- slot_write  out  2  one-cycle commit pulse to pipeline p's slot table
- slot_index  out  $clog2(n_slots)  slot being written
- slot_base  out  mem_addr_width  absolute region base
- slot_size  out  mem_addr_width  region length
- slot_init  out  mem_addr_width  initial tap offset
- alloc_busy  out  1  high whenever state != IDLE or a request is pending
- alloc_fail  out  2  sticky per-pipeline failure flag
- alloc_overrun  out  1  sticky: request dropped (pending slot full)

Behaviour:
- Reset (async, reset_n low): all outputs 0; state IDLE; ptr[0..1]=0, count[0..1]=0, pending empty.
- Half size H = 2^(mem_addr_width-1). Base of pipeline p = p*H + ptr[p].
- Request capture: alloc_delay[p] high latches {p,size,init} into a 1-entry pending register. If alloc_delay==2'b11, bit 0 is taken, bit 1 sets alloc_overrun. If pending is already full, the request is dropped and alloc_overrun set (sticky until reset_n).
- FSM:
  - IDLE: if pending valid, pop it → CHECK.
  - CHECK (1 cycle): fail if size==0, size > H-ptr[p], init >= size, or count[p]==n_slots. Fail → alloc_fail[p]<=1, → IDLE, no memory or slot writes. Pass → CLEAR with clear_addr=base.
  - CLEAR: one zero-write per cycle (mem_clear_we=1), addresses base..base+size-1 ascending; after the last write → COMMIT.
  - COMMIT (1 cycle): slot_write[p]=1; slot_index=count[p]; slot_base=base; slot_size=size; slot_init=init (truncated to mem_addr_width, already range-checked); ptr[p]+=size; count[p]+=1 → IDLE.
- Latency: request pulse at edge T → CHECK cycle T+1 → mem_clear_we high cycles T+2..T+1+size → slot_write at T+2+size.
- slot_* fields hold their value until the next commit.
- pipeline_full_reset[p]:
  - Clears ptr[p], count[p], alloc_fail[p]; discards a pending request for p.
  - If the in-flight request targets p, it is aborted immediately: mem_clear_we drops next cycle, no slot_write, → IDLE.
  - Full reset and alloc_delay[p] in the same cycle: reset wins, request dropped silently (no overrun).
  - A full reset of the other pipeline does not disturb an in-flight request.
- No wrap-around: ptr[p] never exceeds H; an exact fill (ptr==H) is legal and any further request fails.
- Size/init upper bits beyond mem_addr_width are included in the range checks, not truncated before them.

Test Plan:
- Reset then alloc_delay=2'b01, size=4, init=2 → mem_clear_we cycles T+2..T+5 at addrs 0..3; slot_write=01 at T+6 with index 0, base 0, size 4, init 2.
- Second alloc on pipe 0 size=3, then alloc on pipe 1 size=2 → pipe 0 commits base 4, index 1; pipe 1 clears 32768..32769 and commits base 32768, index 0.
- Error checks: size=0, init=5/size=5, and size=32769 on an empty half → each sets alloc_fail[p] with no mem_clear_we or slot_write. 16 successful size=1 allocs followed by a 17th → fail.
- Back-to-back: two requests while busy → first pending and served, second sets alloc_overrun; alloc_delay=2'b11 → pipe 0 served, overrun set.
- Abort: pipeline_full_reset[0] mid-CLEAR of a size=100 pipe-0 request → no slot_write, alloc_fail[0]=0. Next pipe-0 alloc size=1 → base 0, index 0.
- reset_n asserted mid-CLEAR → all outputs 0 asynchronously; after release, a size=1 request on pipe 1 commits base 32768.
